// File: rtl/fp_divider.sv
// Sequential single-precision divider, z = x / y, one quotient bit per enabled cycle.
// Shares the run/en/stall handshake of the shift-add FP multiplier.
module fp_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        en,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic        stall,
  output logic [31:0] z
);

  localparam logic [4:0] LAST = 5'd26;

  logic [4:0]  s;
  logic [25:0] rem, quo;

  logic [23:0] mx, my;
  logic [25:0] r, d, sel, qprev;
  logic        qbit;

  assign mx    = {1'b1, x[22:0]};
  assign my    = {1'b1, y[22:0]};
  assign r     = (s == 5'd0) ? {2'b00, mx} : rem;
  assign d     = r - {2'b00, my};
  assign qbit  = ~d[25];
  assign sel   = qbit ? d : r;
  assign qprev = (s == 5'd0) ? 26'd0 : quo;
  assign stall = run & (s != LAST);

  // R/Q only advance while bits are still being produced, so the result
  // stays put while run is held with S parked at 26.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s   <= 5'd0;
      rem <= 26'd0;
      quo <= 26'd0;
    end else if (en) begin
      s <= run ? ((s == LAST) ? LAST : s + 5'd1) : 5'd0;
      if (run && s != LAST) begin
        rem <= {sel[24:0], 1'b0};
        quo <= {qprev[24:0], qbit};
      end
    end
  end

  logic [24:0]        m;
  logic               carry;
  logic [22:0]        frac;
  logic [7:0]         xe, ye;
  logic               sign;
  logic signed [9:0]  e;

  assign m    = quo[25] ? quo[25:1] : quo[24:0];
  // m+1 carries out of 25 bits only when m is all ones; otherwise the
  // rounded fraction is (m+1)>>1 restricted to 23 bits.
  assign carry = &m;
  assign frac  = carry ? 23'd0 : (m[23:1] + {22'd0, m[0]});
  assign xe    = x[30:23];
  assign ye    = y[30:23];
  assign sign  = x[31] ^ y[31];
  assign e     = $signed({2'b00, xe} - {2'b00, ye} + 10'd126
                         + {9'd0, quo[25]} + {9'd0, carry});

  always_comb begin
    z = {sign, e[7:0], frac};
    if (xe == 8'd0)             z = 32'd0;
    else if (ye == 8'd0)        z = {sign, 8'hFF, 23'd0};
    else if (e >= 10'sd255)     z = {sign, 8'hFF, 23'd0};
    else if (e <= 10'sd0)       z = 32'd0;
  end

endmodule

// File: tb/tb_fp_divider.sv
// Scoreboard bench for fp_divider: expected quotients queued at issue, checked at completion.
module tb_fp_divider;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        en  = 1'b1;
  logic [31:0] x = 32'd0, y = 32'd0;
  logic        stall;
  logic [31:0] z;

  int tests = 0;
  int fails = 0;
  logic [31:0] sb[$];

  fp_divider dut (.clk(clk), .rst(rst), .run(run), .en(en), .x(x), .y(y),
                  .stall(stall), .z(z));

  always #5 clk = ~clk;

  logic [31:0] vec [0:9][0:2] = '{
    '{32'h40C00000, 32'h40000000, 32'h40400000},
    '{32'h3F800000, 32'h3F800000, 32'h3F800000},
    '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB},
    '{32'h00000000, 32'h40000000, 32'h00000000},
    '{32'h3F800000, 32'h00000000, 32'h7F800000},
    '{32'hBF800000, 32'h00000000, 32'hFF800000},
    '{32'h00000000, 32'h00000000, 32'h00000000},
    '{32'h7F000000, 32'h00800000, 32'h7F800000},
    '{32'h00800000, 32'h7F000000, 32'h00000000},
    '{32'hC0C00000, 32'h40000000, 32'hC0400000}
  };

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    x = a; y = b; run = 1'b1; en = 1'b1;
    sb.push_back(exp);
  endtask

  // Waits for stall to drop, counting enabled edges, then checks the queued result.
  task automatic wait_done(input string name, input bit toggle_en,
                           output int en_edges, output int clks);
    logic [31:0] exp;
    en_edges = 0; clks = 0;
    #1;
    while (stall && clks < 300) begin
      @(posedge clk);
      if (en) en_edges++;
      clks++;
      @(negedge clk);
      if (toggle_en) en = ~en;
      #1;
    end
    tests++;
    if (stall) begin
      fails++;
      $display("FAIL %s timeout: stall still high after %0d clocks", name, clks);
    end
    exp = sb.pop_front();
    tests++;
    if (z !== exp) begin
      fails++;
      $display("FAIL %s z: got %h expected %h (x=%h y=%h)", name, z, exp, x, y);
    end
  endtask

  task automatic finish_op();
    @(negedge clk);
    run = 1'b0; en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; run = 1'b0;
    @(negedge clk); #1;
    tests++;
    if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b expected 0", stall); end
    tests++;
    if (z !== 32'd0) begin fails++; $display("FAIL reset_z: got %h expected 0", z); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_timing();
    int ee, cc;
    start_op(vec[0][0], vec[0][1], vec[0][2]);
    #1;
    tests++;
    if (stall !== 1'b1) begin fails++; $display("FAIL timing_start: stall got %b expected 1", stall); end
    wait_done("timing_6div2", 1'b0, ee, cc);
    tests++;
    if (ee != 26) begin fails++; $display("FAIL timing_cycles: got %0d expected 26", ee); end
    finish_op();
    #1;
    tests++;
    if (stall !== 1'b0) begin fails++; $display("FAIL idle_stall: got %b expected 0", stall); end
  endtask

  task automatic test_vectors();
    int ee, cc;
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      start_op(vec[i][0], vec[i][1], vec[i][2]);
      wait_done($sformatf("vec%0d", i), 1'b0, ee, cc);
      finish_op();
    end
  endtask

  task automatic test_en_toggle();
    int ee, cc;
    @(negedge clk);
    start_op(vec[0][0], vec[0][1], vec[0][2]);
    wait_done("en_toggle", 1'b1, ee, cc);
    tests++;
    if (ee != 26) begin fails++; $display("FAIL en_toggle_edges: got %0d expected 26", ee); end
    tests++;
    if (cc < 50) begin fails++; $display("FAIL en_toggle_clks: got %0d expected >= 50", cc); end
    finish_op();
  endtask

  task automatic test_reset_mid();
    int ee, cc;
    @(negedge clk);
    start_op(vec[9][0], vec[9][1], vec[9][2]);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (stall !== 1'b1) begin fails++; $display("FAIL rst_mid_stall: got %b expected 1", stall); end
    @(negedge clk);
    rst = 1'b1;
    wait_done("rst_mid", 1'b0, ee, cc);
    tests++;
    if (ee != 26) begin fails++; $display("FAIL rst_mid_cycles: got %0d expected 26", ee); end
    finish_op();
  endtask

  task automatic test_back_to_back();
    int ee, cc;
    @(negedge clk);
    x = vec[7][0]; y = vec[7][1]; run = 1'b1; en = 1'b1;
    repeat (5) @(negedge clk);
    run = 1'b0;
    #1;
    tests++;
    if (stall !== 1'b0) begin fails++; $display("FAIL early_drop_stall: got %b expected 0", stall); end
    @(negedge clk);
    start_op(vec[2][0], vec[2][1], vec[2][2]);
    wait_done("after_abort", 1'b0, ee, cc);
    tests++;
    if (ee != 26) begin fails++; $display("FAIL after_abort_cycles: got %0d expected 26", ee); end
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    start_op(vec[1][0], vec[1][1], vec[1][2]);
    wait_done("back_to_back", 1'b0, ee, cc);
    finish_op();
  endtask

  initial begin
    test_reset();
    test_timing();
    test_vectors();
    test_en_toggle();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
